// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - plays a range of pattern buffer fields out as a byte stream
module pattern_sequencer #(
    parameter int NBUF   = 8,
    parameter int NFIELD = 32,
    parameter int DW     = 8,
    localparam int BW    = $clog2(NBUF),
    localparam int FW    = $clog2(NFIELD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [BW-1:0] first_buf,
    input  logic [BW-1:0] last_buf,
    input  logic [FW-1:0] last_field,
    output logic [BW-1:0] bufp,
    output logic [FW-1:0] fieldp,
    input  logic [DW-1:0] field_byte,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [15:0]   byte_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bufp_q, bufp_d;
    logic [FW-1:0] fieldp_q, fieldp_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   byte_count_q, byte_count_d;
    logic [BW-1:0] first_buf_q, first_buf_d;
    logic [BW-1:0] last_buf_q, last_buf_d;
    logic [FW-1:0] last_field_q, last_field_d;

    logic          handshake;
    logic [BW-1:0] bufp_inc;

    assign handshake = out_valid_q && out_ready;
    // Buffer index steps upward and wraps from the top buffer back to zero.
    assign bufp_inc  = (bufp_q == BW'(NBUF - 1)) ? '0 : bufp_q + BW'(1);

    // Next-state and datapath decisions for the playback FSM.
    always_comb begin
        state_d      = state_q;
        bufp_d       = bufp_q;
        fieldp_d     = fieldp_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        byte_count_d = byte_count_q;
        first_buf_d  = first_buf_q;
        last_buf_d   = last_buf_q;
        last_field_d = last_field_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    first_buf_d  = first_buf;
                    last_buf_d   = last_buf;
                    last_field_d = last_field;
                    bufp_d       = first_buf;
                    fieldp_d     = '0;
                    byte_count_d = '0;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (stop) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_data_d  = field_byte;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    byte_count_d = byte_count_q + 16'd1;
                    out_valid_d  = 1'b0;
                    if (fieldp_q != last_field_q) begin
                        fieldp_d = fieldp_q + FW'(1);
                        state_d  = S_FETCH;
                    end else if (bufp_q != last_buf_q) begin
                        fieldp_d = '0;
                        bufp_d   = bufp_inc;
                        state_d  = S_FETCH;
                    end else if (loop_en) begin
                        fieldp_d = '0;
                        bufp_d   = first_buf_q;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
                // An abort wins over any advance; an accepted byte still counts.
                if (stop) begin
                    bufp_d      = bufp_q;
                    fieldp_d    = fieldp_q;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bufp_q       <= '0;
            fieldp_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            byte_count_q <= '0;
            first_buf_q  <= '0;
            last_buf_q   <= '0;
            last_field_q <= '0;
        end else begin
            state_q      <= state_d;
            bufp_q       <= bufp_d;
            fieldp_q     <= fieldp_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            byte_count_q <= byte_count_d;
            first_buf_q  <= first_buf_d;
            last_buf_q   <= last_buf_d;
            last_field_q <= last_field_d;
        end
    end

    assign bufp       = bufp_q;
    assign fieldp     = fieldp_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign byte_count = byte_count_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [2:0]  first_buf = '0;
    logic [2:0]  last_buf = '0;
    logic [4:0]  last_field = '0;
    logic [2:0]  bufp;
    logic [4:0]  fieldp;
    logic [7:0]  field_byte;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] byte_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Pattern store model: each field holds its own address.
    assign field_byte = {bufp, fieldp};

    pattern_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .first_buf  (first_buf),
        .last_buf   (last_buf),
        .last_field (last_field),
        .bufp       (bufp),
        .fieldp     (fieldp),
        .field_byte (field_byte),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    // Expected stream for a non-looping range.
    task automatic push_range(input logic [2:0] fb, input logic [2:0] lb, input logic [4:0] lf);
        logic [2:0] b;
        b = fb;
        for (int k = 0; k < 8; k++) begin
            for (int f = 0; f <= int'(lf); f++) exp_q.push_back({b, 5'(f)});
            if (b == lb) break;
            b = b + 3'd1;
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after acceptance.
    task automatic do_start(input logic [2:0] fb, input logic [2:0] lb, input logic [4:0] lf);
        @(negedge clk);
        start = 1'b1; stop = 1'b0;
        first_buf = fb; last_buf = lb; last_field = lf;
        @(negedge clk);
        start = 1'b0;
        first_buf = ~fb; last_buf = ~lb; last_field = ~lf;
    endtask

    // Consume bytes against the scoreboard until done; optional back-pressure on one byte.
    task automatic drain(input int max_cyc, input int hold_idx, input int hold_len,
                         output int ndone, output int cyc);
        int nbytes;
        int held;
        logic [7:0] exp;
        nbytes = 0; held = 0; ndone = 0; cyc = 0;
        while (cyc < max_cyc && ndone == 0) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
            end else if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte: got %02h, expected no more bytes", out_data);
                    out_ready = 1'b1;
                end else if (nbytes == hold_idx && held < hold_len) begin
                    out_ready = 1'b0;
                    held++;
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL hold_stable: got %02h, expected %02h", out_data, exp_q[0]);
                    end
                end else begin
                    out_ready = 1'b1;
                    exp = exp_q.pop_front();
                    nbytes++;
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL stream_byte: got %02h, expected %02h", out_data, exp);
                    end
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL done_timeout: done seen %0d times, expected 1", ndone);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bytes_missing: %0d left, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle_after(input logic [15:0] exp_cnt);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || byte_count !== exp_cnt) begin
            errors++;
            $display("FAIL idle_after: busy=%b done=%b valid=%b cnt=%0d, expected 0 0 0 %0d",
                     busy, done, out_valid, byte_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bufp !== 3'd0 || fieldp !== 5'd0 || out_data !== 8'h00 || out_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || byte_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: bufp=%0d fieldp=%0d data=%02h valid=%b busy=%b done=%b cnt=%0d, expected all 0",
                     bufp, fieldp, out_data, out_valid, busy, done, byte_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nd, cyc;
        out_ready = 1'b1;
        push_range(3'd2, 3'd3, 5'd3);
        do_start(3'd2, 3'd3, 5'd3);
        drain(100, -1, 0, nd, cyc);
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("FAIL throughput: done after %0d cycles, expected 16", cyc);
        end
        checks++;
        if (byte_count !== 16'd8) begin
            errors++;
            $display("FAIL basic_count: got %0d, expected 8", byte_count);
        end
        check_idle_after(16'd8);
    endtask

    task automatic test_backpressure();
        int nd, cyc;
        push_range(3'd2, 3'd3, 5'd3);
        do_start(3'd2, 3'd3, 5'd3);
        drain(100, 1, 5, nd, cyc);
        out_ready = 1'b1;
        check_idle_after(16'd8);
    endtask

    task automatic test_wrap();
        int nd, cyc;
        push_range(3'd7, 3'd0, 5'd0);
        do_start(3'd7, 3'd0, 5'd0);
        drain(50, -1, 0, nd, cyc);
        check_idle_after(16'd2);
    endtask

    task automatic test_loop_stop();
        int nbytes;
        int cyc;
        logic [7:0] exp;
        logic stopped;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(8'h20);
            exp_q.push_back(8'h21);
        end
        loop_en = 1'b1;
        out_ready = 1'b1;
        do_start(3'd1, 3'd1, 5'd1);
        nbytes = 0; cyc = 0; stopped = 1'b0;
        while (cyc < 60 && !stopped) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL loop_no_done: done=%b, expected 0", done);
            end
            if (out_valid) begin
                exp = exp_q.pop_front();
                checks++;
                if (out_data !== exp) begin
                    errors++;
                    $display("FAIL loop_byte: got %02h, expected %02h", out_data, exp);
                end
                nbytes++;
                if (nbytes == 6) begin
                    stop = 1'b1;
                    out_ready = 1'b0;
                    stopped = 1'b1;
                end
            end
        end
        checks++;
        if (!stopped) begin
            errors++;
            $display("FAIL loop_timeout: saw %0d bytes, expected 6", nbytes);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || byte_count !== 16'd5) begin
            errors++;
            $display("FAIL stop_abort: valid=%b busy=%b done=%b cnt=%0d, expected 0 0 0 5",
                     out_valid, busy, done, byte_count);
        end
        stop = 1'b0;
        loop_en = 1'b0;
        out_ready = 1'b1;
        check_idle_after(16'd5);
        exp_q.delete();
    endtask

    task automatic test_start_stop_busy();
        int nd, cyc;
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        first_buf = 3'd4; last_buf = 3'd5; last_field = 5'd2;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || byte_count !== 16'd5 || {bufp, fieldp} !== 8'h21) begin
            errors++;
            $display("FAIL start_stop_idle: busy=%b cnt=%0d ptr=%02h, expected 0 5 21",
                     busy, byte_count, {bufp, fieldp});
        end
        push_range(3'd2, 3'd3, 5'd3);
        do_start(3'd2, 3'd3, 5'd3);
        start = 1'b1;
        first_buf = 3'd6; last_buf = 3'd6; last_field = 5'd0;
        drain(100, -1, 0, nd, cyc);
        start = 1'b0;
        check_idle_after(16'd8);
    endtask

    task automatic test_async_reset();
        int nd, cyc;
        push_range(3'd2, 3'd3, 5'd3);
        do_start(3'd2, 3'd3, 5'd3);
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h40) begin
            errors++;
            $display("FAIL emit_before_rst: valid=%b data=%02h, expected 1 40", out_valid, out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bufp !== 3'd0 || fieldp !== 5'd0 || out_data !== 8'h00 || out_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || byte_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: bufp=%0d fieldp=%0d data=%02h valid=%b busy=%b done=%b cnt=%0d, expected all 0",
                     bufp, fieldp, out_data, out_valid, busy, done, byte_count);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drain_after_reset: begin
            do_start(3'd2, 3'd3, 5'd3);
            drain(100, -1, 0, nd, cyc);
        end
        check_idle_after(16'd8);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_loop_stop();
        test_start_stop_busy();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NBUF, 8, number of pattern buffers; bufp width is log2(NBUF)=3.
- NFIELD, 32, fields per buffer; fieldp width is log2(NFIELD)=5.
- DW, 8, field byte width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- start, in, 1, begin playback; sampled in IDLE only.
- stop, in, 1, abort playback; sampled in every state.
- loop_en, in, 1, restart at first_buf after last_buf instead of finishing.
- first_buf, in, 3, first buffer index, sampled on accepted start.
- last_buf, in, 3, final buffer index, sampled on accepted start.
- last_field, in, 5, final field index per buffer, sampled on accepted start.
- bufp, out, 3, buffer select driven to the pattern buffer store.
- fieldp, out, 5, field select driven to the pattern buffer store.
- field_byte, in, 8, store read data; combinational function of bufp/fieldp, valid one cycle after they change.
- out_data, out, 8, emitted field byte.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, consumer accepts out_data.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse on normal completion.
- byte_count, out, 16, bytes accepted since last accepted start; wraps 0xFFFF->0.

Function
REQ-003 States: IDLE, FETCH, EMIT, DONE; encoding is free.
REQ-004 IDLE: start=1 and stop=0 latches first_buf, last_buf, last_field; sets bufp=first_buf, fieldp=0, byte_count=0; next state FETCH.
REQ-005 IDLE with start=1 and stop=1: stays IDLE; no register changes.
REQ-006 FETCH: one cycle; captures field_byte into out_data; sets out_valid=1; next state EMIT.
REQ-007 EMIT: out_valid and out_data are held stable until out_ready=1.
REQ-008 On out_valid=1 and out_ready=1 in EMIT, byte_count increments and out_valid clears in the same edge.
REQ-009 Advance on handshake, fieldp != latched last_field: fieldp+1; next state FETCH.
REQ-010 Advance on handshake, fieldp == last_field and bufp != last_buf: fieldp=0; bufp+1 modulo 8 (7->0); next state FETCH.
REQ-011 Advance on handshake, fieldp == last_field, bufp == last_buf, loop_en=1: fieldp=0; bufp=latched first_buf; next state FETCH.
REQ-012 Advance on handshake, fieldp == last_field, bufp == last_buf, loop_en=0: next state DONE.
REQ-013 DONE: done=1 for exactly one cycle; next state IDLE; bufp/fieldp retain last values.
REQ-014 Steady-state throughput is one byte per two cycles when out_ready is held high.
REQ-015 loop_en is sampled live at each end-of-range decision.
REQ-016 first_buf > last_buf is legal: bufp traverses upward with 7->0 wrap until it equals last_buf.
REQ-017 stop=1 in FETCH or EMIT: next state IDLE; out_valid=0 next cycle; no done pulse; the byte pending in EMIT is discarded (the only permitted valid-drop without ready).
REQ-018 stop coincident with an EMIT handshake: the byte counts as accepted; the next state is still IDLE.
REQ-019 start outside IDLE is ignored.
REQ-020 out_data holds its value after out_valid falls.

Reset
REQ-021 rst=1 forces state IDLE, bufp=0, fieldp=0, out_data=0x00, out_valid=0, busy=0, done=0, byte_count=0, and clears latched config to 0, immediately and independent of clk.
REQ-022 rst mid-playback aborts with no done pulse; first accepted start after rst release behaves per REQ-004.

Verification
REQ-023 The bench covers these scenarios:
- Store byte = {bufp,fieldp}; start with first_buf=2, last_buf=3, last_field=3, loop_en=0, out_ready=1 -> emits 0x40,0x41,0x42,0x43,0x60,0x61,0x62,0x63; done pulse; byte_count=8; busy drops.
- Same as previous with out_ready low 5 cycles on 2nd byte -> 0x41 held stable 5 cycles; no byte lost or duplicated.
- first_buf=7, last_buf=0, last_field=0 -> emits 0xE0 then 0x00; done.
- loop_en=1, first_buf=last_buf=1, last_field=1 -> 0x20,0x21,0x20,0x21...; stop in EMIT -> out_valid=0 next cycle; IDLE; no done.
- start and stop high together in IDLE -> stays IDLE, busy=0; start while busy -> no restart; byte sequence unaffected.
- rst asserted asynchronously mid-EMIT -> all outputs at reset values before next clk edge; fresh start replays from the first byte.
